// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// wb_req_t describes one writeback request at the default port widths.
package regfile_write_arbiter_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ADDRESS_WIDTH_DEF = 5;
  localparam int STARVE_CNT_WIDTH  = 4;
  localparam int REG_ZERO          = 0;

  typedef enum logic {
    PRIO_P  = 1'b0,
    FORCE_L = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                         valid;
    logic [ADDRESS_WIDTH_DEF-1:0] rd;
    logic [DATA_WIDTH_DEF-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the pipeline (P)
// and the long-latency return path (L): P has priority, starved L gets forced in.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p_valid,
  input  logic [ADDRESS_WIDTH-1:0] p_rd,
  input  logic [DATA_WIDTH-1:0]    p_data,
  output logic                     p_ready,
  input  logic                     l_valid,
  input  logic [ADDRESS_WIDTH-1:0] l_rd,
  input  logic [DATA_WIDTH-1:0]    l_data,
  output logic                     l_ready,
  output logic                     rf_we,
  output logic [ADDRESS_WIDTH-1:0] rf_a3,
  output logic [DATA_WIDTH-1:0]    rf_wd,
  output logic                     p_stall
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT    = STARVE_CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_M1 = STARVE_CNT_WIDTH'(STARVE_LIMIT - 1);

  arb_state_e                  state;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt;
  logic                        l_starved;
  logic                        xfer;
  logic [ADDRESS_WIDTH-1:0]    sel_rd;
  logic [DATA_WIDTH-1:0]       sel_data;

  // Grants depend only on state and the two valids, never on rd or data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    p_ready = 1'b0;
    l_ready = 1'b0;
    case (state)
      PRIO_P: begin
        if (p_valid)      p_ready = 1'b1;
        else if (l_valid) l_ready = 1'b1;
      end
      FORCE_L: begin
        if (l_valid)      l_ready = 1'b1;
        else if (p_valid) p_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign p_stall   = p_valid & ~p_ready;
  assign l_starved = l_valid & ~l_ready;
  assign xfer      = p_ready | l_ready;
  assign sel_rd    = p_ready ? p_rd   : l_rd;
  assign sel_data  = p_ready ? p_data : l_data;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state      <= PRIO_P;
      starve_cnt <= '0;
    end else begin
      case (state)
        PRIO_P: begin
          if (l_starved) begin
            starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
            // The wait that brings the count to the limit hands the next cycle to L.
            if (starve_cnt >= LIMIT_M1) state <= FORCE_L;
          end else begin
            starve_cnt <= '0;
          end
        end
        FORCE_L: begin
          // Either L transfers now or it has gone idle; both end the forced window.
          state      <= PRIO_P;
          starve_cnt <= '0;
        end
        default: begin
          state      <= PRIO_P;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // Write port: one-cycle pulse per accepted transfer; x0 targets are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_a3 <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= xfer && (sel_rd != ADDRESS_WIDTH'(REG_ZERO));
      if (xfer && (sel_rd != ADDRESS_WIDTH'(REG_ZERO))) begin
        rf_a3 <= sel_rd;
        rf_wd <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter against a
// wait-counting reference model, plus directed reset/starvation/x0 cases.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  wb_req_t       p_req, l_req;
  logic          p_valid, l_valid, p_ready, l_ready, rf_we, p_stall;
  logic [AW-1:0] p_rd, l_rd, rf_a3;
  logic [DW-1:0] p_data, l_data, rf_wd;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            l_wait;
  logic          m_we, m_gp, m_gl;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;

  assign p_valid = p_req.valid;
  assign p_rd    = p_req.rd;
  assign p_data  = p_req.data;
  assign l_valid = l_req.valid;
  assign l_rd    = l_req.rd;
  assign l_data  = l_req.data;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
    .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data), .l_ready(l_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .p_stall(p_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    l_wait = 0;
    m_we   = 1'b0;
    m_a3   = '0;
    m_wd   = '0;
  endtask

  // One clock cycle: check grants mid-cycle, then the write port after the edge.
  task automatic step();
    bit            force_now, gp, gl;
    logic [AW-1:0] rd;
    @(negedge clk);
    force_now = (l_wait >= LIM);
    gp = 1'b0;
    gl = 1'b0;
    if (force_now) begin
      gl = l_req.valid;
      gp = !gl && p_req.valid;
    end else begin
      gp = p_req.valid;
      gl = !gp && l_req.valid;
    end
    check("p_ready", 64'(p_ready), 64'(gp));
    check("l_ready", 64'(l_ready), 64'(gl));
    check("p_stall", 64'(p_stall), 64'(p_req.valid && !gp));
    if (force_now)                  l_wait = 0;
    else if (l_req.valid && !gl)    l_wait = l_wait + 1;
    else                            l_wait = 0;
    m_gp = gp;
    m_gl = gl;
    m_we = 1'b0;
    if (gp || gl) begin
      rd = gp ? p_req.rd : l_req.rd;
      if (rd != '0) begin
        m_we = 1'b1;
        m_a3 = rd;
        m_wd = gp ? p_req.data : l_req.data;
      end
    end
    @(posedge clk);
    #1;
    check("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      check("rf_a3", 64'(rf_a3), 64'(m_a3));
      check("rf_wd", 64'(rf_wd), 64'(m_wd));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_a3", 64'(rf_a3), 64'd0);
    check("rst_rf_wd", 64'(rf_wd), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic new_p();
    p_req.valid = ($urandom_range(0, 9) < 8);
    p_req.rd    = AW'($urandom_range(0, 31));
    p_req.data  = $urandom;
  endtask

  task automatic new_l();
    l_req.valid = ($urandom_range(0, 9) < 5);
    l_req.rd    = AW'($urandom_range(0, 31));
    l_req.data  = $urandom;
  endtask

  initial begin
    p_req = '0;
    l_req = '0;
    rst_n = 1'b1;
    #2;

    // Reset with both requesters asserting; first grant after release goes to P.
    p_req = '{valid: 1'b1, rd: 5'd3, data: 32'h1234_5678};
    l_req = '{valid: 1'b1, rd: 5'd4, data: 32'h8765_4321};
    do_reset();
    #1;
    check("first_grant_p", 64'(p_ready), 64'd1);
    check("first_grant_l", 64'(l_ready), 64'd0);
    step();

    // P-only single write.
    l_req = '0;
    p_req = '{valid: 1'b1, rd: 5'd5, data: 32'hDEAD_BEEF};
    do_reset();
    #1;
    check("p_only_ready", 64'(p_ready), 64'd1);
    step();
    p_req.valid = 1'b0;
    check("p_only_we", 64'(rf_we), 64'd1);
    check("p_only_a3", 64'(rf_a3), 64'd5);
    check("p_only_wd", 64'(rf_wd), 64'hDEAD_BEEF);
    step();
    check("p_only_we_drop", 64'(rf_we), 64'd0);

    // Starvation: P every cycle, L pending from cycle 0 is forced in on cycle 4.
    do_reset();
    l_req = '{valid: 1'b1, rd: 5'd7, data: 32'h11};
    for (int c = 0; c < 7; c++) begin
      p_req = '{valid: 1'b1, rd: AW'(c + 10), data: 32'hA000_0000 + c};
      #1;
      if (c == 4) begin
        check("starve_l_grant", 64'(l_ready), 64'd1);
        check("starve_p_stall", 64'(p_stall), 64'd1);
      end else begin
        check("starve_p_grant", 64'(p_ready), 64'd1);
      end
      step();
      if (c == 4) begin
        check("starve_a3", 64'(rf_a3), 64'd7);
        check("starve_wd", 64'(rf_wd), 64'h11);
        l_req.valid = 1'b0;
      end
    end
    p_req = '0;

    // x0 write is accepted but never reaches the register file.
    do_reset();
    l_req = '{valid: 1'b1, rd: 5'd0, data: 32'hFFFF_FFFF};
    #1;
    check("x0_ready", 64'(l_ready), 64'd1);
    step();
    check("x0_we", 64'(rf_we), 64'd0);
    l_req = '0;

    // Same rd from both sides: P first, then L.
    do_reset();
    p_req = '{valid: 1'b1, rd: 5'd9, data: 32'hAAAA_0001};
    l_req = '{valid: 1'b1, rd: 5'd9, data: 32'hBBBB_0002};
    #1;
    check("same_rd_p", 64'(p_ready), 64'd1);
    check("same_rd_l", 64'(l_ready), 64'd0);
    step();
    check("same_rd_wd_p", 64'(rf_wd), 64'hAAAA_0001);
    p_req.valid = 1'b0;
    #1;
    check("same_rd_l2", 64'(l_ready), 64'd1);
    step();
    check("same_rd_a3_l", 64'(rf_a3), 64'd9);
    check("same_rd_wd_l", 64'(rf_wd), 64'hBBBB_0002);
    l_req = '0;

    // Async reset while rf_we is high.
    do_reset();
    p_req = '{valid: 1'b1, rd: 5'd3, data: 32'h0BAD_F00D};
    step();
    p_req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 64'(rf_we), 64'd0);
    check("async_rst_a3", 64'(rf_a3), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p_req = '{valid: 1'b1, rd: 5'd1, data: 32'h1};
    l_req = '{valid: 1'b1, rd: 5'd2, data: 32'h2};
    #1;
    check("async_rst_prio_p", 64'(p_ready), 64'd1);
    for (int c = 0; c < 6; c++) step();

    // Randomized traffic; requesters hold each request until it is accepted.
    do_reset();
    new_p();
    new_l();
    for (int c = 0; c < 2000; c++) begin
      step();
      if (m_gp || !p_req.valid) new_p();
      if (m_gl || !l_req.valid) new_l();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
